// File: rtl/lab3_cpu.sv
// lab3_cpu: single-cycle accumulator core, 256x9 ROM, 16x8 regs, 256x8 RAM.
// Optional DYN_COUNT_EN adds the dyn_count executed-instruction counter.
module lab3_cpu #(
  parameter string IMEM_FILE = "machine_code.txt",
  parameter string DMEM_FILE = ""
) (
  input  logic        clock_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  start_addr,
`ifdef DYN_COUNT_EN
  output logic [15:0] dyn_count,
`endif
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_e;

  typedef enum logic [3:0] {
    OP_HALT, OP_LDI, OP_PUT, OP_GET,
    OP_ADD,  OP_SUB, OP_AND, OP_OR,
    OP_XOR,  OP_SHL, OP_SHR, OP_LD,
    OP_ST,   OP_BZ,  OP_BNZ, OP_JMP
  } op_e;

  logic [8:0] imem [256];
  logic [7:0] dmem [256];
  logic [7:0] rf   [16];

  state_e     state, state_n;
  logic [7:0] pc, pc_n;
  logic [7:0] acc, acc_n;
  logic       done_n;
  logic       rf_we;
  logic       dm_we;
  logic       exec;

  logic [8:0] instr;
  op_e        op;
  logic [4:0] f;
  logic [7:0] rn;
  logic [7:0] br_pc;

  assign instr = imem[pc];
  assign op    = op_e'(instr[8:5]);
  assign f     = instr[4:0];
  assign rn    = rf[f[3:0]];
  assign br_pc = pc + {{3{f[4]}}, f};
  assign exec  = (state == RUN) && !start_i;

  always_comb begin
    state_n = state;
    pc_n    = pc + 8'd1;
    acc_n   = acc;
    done_n  = done;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    if (start_i) begin
      pc_n    = start_addr;
      state_n = RUN;
      done_n  = 1'b0;
    end else if (state == IDLE) begin
      pc_n = pc;
    end else begin
      unique case (op)
        OP_HALT: begin
          pc_n    = pc;
          state_n = IDLE;
          done_n  = 1'b1;
        end
        OP_LDI: acc_n = {3'b000, f};
        OP_PUT: rf_we = 1'b1;
        OP_GET: acc_n = rn;
        OP_ADD: acc_n = acc + rn;
        OP_SUB: acc_n = acc - rn;
        OP_AND: acc_n = acc & rn;
        OP_OR:  acc_n = acc | rn;
        OP_XOR: acc_n = acc ^ rn;
        OP_SHL: acc_n = acc << f[2:0];
        OP_SHR: acc_n = acc >> f[2:0];
        OP_LD:  acc_n = dmem[rn];
        OP_ST:  dm_we = 1'b1;
        OP_BZ:  if (acc == 8'd0) pc_n = br_pc;
        OP_BNZ: if (acc != 8'd0) pc_n = br_pc;
        OP_JMP: pc_n = rn;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      pc    <= 8'd0;
      acc   <= 8'd0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      acc   <= acc_n;
      done  <= done_n;
    end
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'd0;
    end else if (rf_we) begin
      rf[f[3:0]] <= acc;
    end
  end

  // data RAM keeps its contents across reset
  always_ff @(posedge clock_i) begin
    if (dm_we) dmem[rn] <= acc;
  end

`ifdef DYN_COUNT_EN
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dyn_count <= 16'd0;
    end else if (start_i) begin
      dyn_count <= 16'd0;
    end else if (exec && dyn_count != 16'hFFFF) begin
      dyn_count <= dyn_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lab3_cpu.sv
// tb_lab3_cpu: scoreboard bench for lab3_cpu.
// Programs are poked into the ROM; expected results queued per start.
module tb_lab3_cpu;

  logic        clock_i;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  start_addr;
  logic        done;
`ifdef DYN_COUNT_EN
  logic [15:0] dyn_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] acc;
    logic [7:0] pc;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  lab3_cpu #(
    .IMEM_FILE (""),
    .DMEM_FILE ("")
  ) dut (
    .clock_i    (clock_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .start_addr (start_addr),
`ifdef DYN_COUNT_EN
    .dyn_count  (dyn_count),
`endif
    .done       (done)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] enc(input logic [3:0] op,
                                     input logic [4:0] f);
    return {op, f};
  endfunction

  task automatic run(input logic [7:0] addr, input logic [7:0] eacc,
                     input logic [7:0] epc, input int ecyc);
    exp_t e;
    int   cyc;
    sb.push_back('{acc: eacc, pc: epc, cyc: ecyc});
    @(negedge clock_i);
    start_i    = 1'b1;
    start_addr = addr;
    @(negedge clock_i);
    chk("done_drop", {31'd0, done}, 32'd0);
    chk("start_pc", {24'd0, dut.pc}, {24'd0, addr});
`ifdef DYN_COUNT_EN
    chk("dyn_clr", {16'd0, dyn_count}, 32'd0);
`endif
    start_i = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clock_i);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    chk("done_rise", {31'd0, done}, 32'd1);
    chk("cycles", cyc, e.cyc);
    chk("acc", {24'd0, dut.acc}, {24'd0, e.acc});
    chk("halt_pc", {24'd0, dut.pc}, {24'd0, e.pc});
`ifdef DYN_COUNT_EN
    chk("dyn_count", {16'd0, dyn_count}, e.cyc);
`endif
    repeat (3) @(posedge clock_i);
    #1;
    chk("idle_done", {31'd0, done}, 32'd1);
    chk("idle_pc", {24'd0, dut.pc}, {24'd0, e.pc});
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    start_addr = 8'd0;
    for (int i = 0; i < 256; i++) begin
      dut.imem[i] = 9'd0;
      dut.dmem[i] = 8'd0;
    end
    dut.dmem[4] = 8'hA5;
    // arithmetic / store / shift
    dut.imem[100] = enc(1, 5);
    dut.imem[101] = enc(2, 1);
    dut.imem[102] = enc(1, 3);
    dut.imem[103] = enc(4, 1);
    dut.imem[104] = enc(2, 2);
    dut.imem[105] = enc(1, 9);
    dut.imem[106] = enc(12, 2);
    dut.imem[107] = enc(1, 5'h1F);
    dut.imem[108] = enc(9, 3);
    // countdown loop
    dut.imem[20] = enc(1, 4);
    dut.imem[21] = enc(2, 3);
    dut.imem[22] = enc(1, 1);
    dut.imem[23] = enc(2, 4);
    dut.imem[24] = enc(3, 3);
    dut.imem[25] = enc(5, 4);
    dut.imem[26] = enc(14, 5'h1F);
    // logic ops, BZ skip, SHR, LD
    dut.imem[40] = enc(1, 5'h0C);
    dut.imem[41] = enc(2, 5);
    dut.imem[42] = enc(1, 5'h0A);
    dut.imem[43] = enc(6, 5);
    dut.imem[44] = enc(7, 5);
    dut.imem[45] = enc(8, 5);
    dut.imem[46] = enc(13, 2);
    dut.imem[47] = enc(1, 1);
    dut.imem[48] = enc(1, 5'h10);
    dut.imem[49] = enc(10, 2);
    dut.imem[50] = enc(2, 6);
    dut.imem[51] = enc(11, 6);
    // infinite loop for reset abort
    dut.imem[60] = enc(1, 5);
    dut.imem[61] = enc(14, 0);
    // restart program: SUB wrap, JMP back to 136
    dut.imem[138] = enc(1, 5'h11);
    dut.imem[139] = enc(9, 3);
    dut.imem[140] = enc(2, 10);
    dut.imem[141] = enc(1, 1);
    dut.imem[142] = enc(2, 11);
    dut.imem[143] = enc(1, 0);
    dut.imem[144] = enc(5, 11);
    dut.imem[145] = enc(15, 10);
    // pc wrap 255 -> 0
    dut.imem[253] = enc(1, 3);
    dut.imem[254] = enc(9, 1);
    dut.imem[255] = enc(2, 9);
    dut.imem[0]   = enc(1, 1);
    dut.imem[1]   = enc(4, 9);

    repeat (10) @(posedge clock_i);
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pc", {24'd0, dut.pc}, 32'd0);
    chk("rst_acc", {24'd0, dut.acc}, 32'd0);
    chk("rst_dmem8", {24'd0, dut.dmem[8]}, 32'd0);
    @(negedge clock_i);
    rst_ni = 1'b1;
    repeat (5) @(posedge clock_i);
    #1;
    chk("idle_nostart_pc", {24'd0, dut.pc}, 32'd0);
    chk("idle_nostart_done", {31'd0, done}, 32'd0);

    run(8'd93, 8'h00, 8'd93, 1);
    run(8'd100, 8'hF8, 8'd109, 10);
    chk("dmem8", {24'd0, dut.dmem[8]}, 32'd9);
    chk("r2", {24'd0, dut.rf[2]}, 32'd8);
    run(8'd20, 8'h00, 8'd27, 14);
    run(8'd40, 8'hA5, 8'd52, 12);
    chk("r6", {24'd0, dut.rf[6]}, 32'd4);
    run(8'd138, 8'hFF, 8'd136, 9);
    run(8'd253, 8'h07, 8'd2, 6);
    chk("r9", {24'd0, dut.rf[9]}, 32'd6);

    // abort a running loop with reset
    @(negedge clock_i);
    start_i    = 1'b1;
    start_addr = 8'd60;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (6) @(negedge clock_i);
    chk("loop_acc", {24'd0, dut.acc}, 32'd5);
    chk("loop_pc", {24'd0, dut.pc}, 32'd61);
    chk("loop_done", {31'd0, done}, 32'd0);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_acc", {24'd0, dut.acc}, 32'd0);
    chk("abort_pc", {24'd0, dut.pc}, 32'd0);
    chk("abort_r9", {24'd0, dut.rf[9]}, 32'd0);
`ifdef DYN_COUNT_EN
    chk("abort_dyn", {16'd0, dyn_count}, 32'd0);
`endif
    @(negedge clock_i);
    rst_ni = 1'b1;
    repeat (5) @(posedge clock_i);
    #1;
    chk("post_abort_pc", {24'd0, dut.pc}, 32'd0);
    chk("post_abort_acc", {24'd0, dut.acc}, 32'd0);
    chk("post_abort_done", {31'd0, done}, 32'd0);

    run(8'd93, 8'h00, 8'd93, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
